// File: rtl/l1_neuron_mac.sv
// Layer-1 neuron engine: per-neuron dot product, bias, rescale, saturate.
// Optional ReLU on the output when L1_NEURON_RELU_EN is defined.
module l1_neuron_mac #(
    parameter int N_IN     = 784,
    parameter int N_NEURON = 15,
    parameter int DW       = 16,
    parameter int FRAC     = 8,
    parameter int AW       = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [9:0]    pix_addr,
    input  logic [DW-1:0] pix_data,
    output logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic [8:0]    b_addr,
    input  logic [DW-1:0] b_data,
    output logic          out_valid,
    output logic [3:0]    out_idx,
    output logic [DW-1:0] out_data
);

    localparam int ACCW = 2*DW + 10;
    localparam int PW   = 2*DW;

    localparam logic [9:0]    ILAST = 10'(N_IN - 1);
    localparam logic [3:0]    NLAST = 4'(N_NEURON - 1);
    localparam logic [AW-1:0] WSTEP = AW'(N_IN);

    localparam logic signed [ACCW-1:0] SMAX =
        {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN =
        {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, MAC, BIAS, EMIT, FIN
    } state_t;

    state_t state, nstate;

    logic signed [ACCW-1:0] acc;
    logic [9:0]             i;
    logic [3:0]             n;
    logic [AW-1:0]          wbase;

    logic go, mac_en, bias_en, emit_en, fin_en;
    logic last_i, last_n;

    logic signed [PW-1:0]   pix_x, w_x, prod;
    logic signed [ACCW-1:0] prod_x, bias_x, r;
    logic [DW-1:0]          sat, res;

    assign last_i = (i == ILAST);
    assign last_n = (n == NLAST);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = MAC;
            MAC:     if (last_i) nstate = BIAS;
            BIAS:    nstate = EMIT;
            EMIT:    nstate = last_n ? FIN : MAC;
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        go      = 1'b0;
        mac_en  = 1'b0;
        bias_en = 1'b0;
        emit_en = 1'b0;
        fin_en  = 1'b0;
        unique case (state)
            IDLE:    go      = start;
            MAC:     mac_en  = 1'b1;
            BIAS:    bias_en = 1'b1;
            EMIT:    emit_en = 1'b1;
            FIN:     fin_en  = 1'b1;
            default: ;
        endcase
    end

    // Full-width sign extension keeps the product exact in 2*DW bits.
    assign pix_x  = {{DW{pix_data[DW-1]}}, pix_data};
    assign w_x    = {{DW{w_data[DW-1]}}, w_data};
    assign prod   = pix_x * w_x;
    assign prod_x = {{(ACCW-PW){prod[PW-1]}}, prod};
    assign bias_x = {{(ACCW-DW-FRAC){b_data[DW-1]}}, b_data, {FRAC{1'b0}}};

    assign r = acc >>> FRAC;

    always_comb begin
        if (r > SMAX)
            sat = {1'b0, {(DW-1){1'b1}}};
        else if (r < SMIN)
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = r[DW-1:0];
    end

`ifdef L1_NEURON_RELU_EN
    assign res = sat[DW-1] ? '0 : sat;
`else
    assign res = sat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            i         <= '0;
            n         <= '0;
            wbase     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (go) begin
                acc   <= '0;
                i     <= '0;
                n     <= '0;
                wbase <= '0;
                busy  <= 1'b1;
            end
            if (mac_en) begin
                acc <= acc + prod_x;
                if (!last_i)
                    i <= i + 10'd1;
            end
            if (bias_en)
                acc <= acc + bias_x;
            if (emit_en) begin
                out_data  <= res;
                out_idx   <= n;
                out_valid <= 1'b1;
                acc       <= '0;
                i         <= '0;
                if (!last_n) begin
                    n     <= n + 4'd1;
                    wbase <= wbase + WSTEP;
                end
            end
            if (fin_en) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    // Running row base avoids a multiplier on the weight address.
    assign pix_addr = i;
    assign w_addr   = wbase + {{(AW-10){1'b0}}, i};
    assign b_addr   = {5'b0, n};

endmodule
